// File: rtl/cec_vector_sequencer.sv
// Exhaustive equivalence-sweep sequencer: drives every input vector to two netlists,
// compares their settled responses. Optional macro CEC_STOP_ON_FAIL_EN ends on first mismatch.
module cec_vector_sequencer #(
  parameter int unsigned IN_W       = 12,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] resp_a_i,
  input  logic [OUT_W-1:0] resp_b_i,
  output logic [IN_W-1:0]  vec_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [IN_W-1:0]  first_vec,
  output logic [OUT_W-1:0] first_diff
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

  state_e           r_state,  w_state_d;
  logic [SetW-1:0]  r_settle, w_settle_d;
  logic [IN_W-1:0]  r_vec,    w_vec_d;
  logic             r_pass,   w_pass_d;
  logic [CNT_W-1:0] r_cnt,    w_cnt_d;
  logic [IN_W-1:0]  r_fvec,   w_fvec_d;
  logic [OUT_W-1:0] r_fdiff,  w_fdiff_d;

  logic [OUT_W-1:0] w_diff;
  logic             w_mism;
  logic             w_end;

  assign w_diff = resp_a_i ^ resp_b_i;
  assign w_mism = |w_diff;

  always_comb begin
    w_state_d  = r_state;
    w_settle_d = r_settle;
    w_vec_d    = r_vec;
    w_pass_d   = r_pass;
    w_cnt_d    = r_cnt;
    w_fvec_d   = r_fvec;
    w_fdiff_d  = r_fdiff;
    w_end      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start && !abort) begin
          w_vec_d    = '0;
          w_settle_d = '0;
          w_pass_d   = 1'b0;
          w_cnt_d    = '0;
          w_fvec_d   = '0;
          w_fdiff_d  = '0;
          w_state_d  = StApply;
        end
      end
      StApply: begin
        if (abort) begin
          w_state_d = StIdle;
        end else if (r_settle == SettleLast) begin
          w_settle_d = '0;
          w_state_d  = StSample;
        end else begin
          w_settle_d = r_settle + SetW'(1);
        end
      end
      StSample: begin
        // Abort discards this cycle's comparison entirely.
        if (abort) begin
          w_state_d = StIdle;
        end else begin
          if (w_mism) begin
            if (r_cnt != '1) w_cnt_d = r_cnt + CNT_W'(1);
            if (r_cnt == '0) begin
              w_fvec_d  = r_vec;
              w_fdiff_d = w_diff;
            end
          end
`ifdef CEC_STOP_ON_FAIL_EN
          w_end = w_mism || (r_vec == '1);
`else
          w_end = (r_vec == '1);
`endif
          if (w_end) begin
            w_pass_d  = (w_cnt_d == '0);
            w_state_d = StDone;
          end else begin
            w_vec_d   = r_vec + IN_W'(1);
            w_state_d = StApply;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_settle <= '0;
      r_vec    <= '0;
      r_pass   <= 1'b0;
      r_cnt    <= '0;
      r_fvec   <= '0;
      r_fdiff  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_settle <= w_settle_d;
      r_vec    <= w_vec_d;
      r_pass   <= w_pass_d;
      r_cnt    <= w_cnt_d;
      r_fvec   <= w_fvec_d;
      r_fdiff  <= w_fdiff_d;
    end
  end

  assign vec_o      = r_vec;
  assign busy       = (r_state == StApply) || (r_state == StSample);
  assign done       = (r_state == StDone);
  assign pass       = r_pass;
  assign mism_cnt   = r_cnt;
  assign first_vec  = r_fvec;
  assign first_diff = r_fdiff;

endmodule

// File: tb/tb_cec_vector_sequencer.sv
// Scoreboarded bench for cec_vector_sequencer: a reference sweep over the error map
// predicts each sweep's result; a monitor checks it whenever done pulses.
module tb_cec_vector_sequencer;

  localparam int unsigned IN_W   = 12;
  localparam int unsigned OUT_W  = 4;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NVEC   = 1 << IN_W;
  localparam int unsigned MAXCNT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [OUT_W-1:0] resp_a, resp_b;
  logic [IN_W-1:0]  vec_o;
  logic             busy, done, pass;
  logic [CNT_W-1:0] mism_cnt;
  logic [IN_W-1:0]  first_vec;
  logic [OUT_W-1:0] first_diff;

  cec_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .resp_a_i(resp_a), .resp_b_i(resp_b), .vec_o(vec_o), .busy(busy), .done(done),
    .pass(pass), .mism_cnt(mism_cnt), .first_vec(first_vec), .first_diff(first_diff)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pass;
    logic [31:0] cnt;
    logic [31:0] fvec;
    logic [31:0] fdiff;
    logic [31:0] vec;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [OUT_W-1:0] err_mask [NVEC];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned t_since  = 0;
  int unsigned start_cyc = 0;

  // Golden netlist: an arbitrary fixed function; optimized = golden ^ error map.
  function automatic logic [OUT_W-1:0] fa(input logic [IN_W-1:0] v);
    logic [15:0] t;
    t = {4'b0, v} * 16'd37 + 16'd11;
    return t[9:6] ^ t[3:0];
  endfunction

  // Optimized netlist output is garbage until the vector has settled.
  always_comb begin
    resp_a = fa(vec_o);
    resp_b = fa(vec_o) ^ err_mask[vec_o];
    if (busy && ((t_since % (SETTLE + 1)) != SETTLE)) resp_b = ~fa(vec_o);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy && !done && !abort) t_since <= 0;
    else t_since <= t_since + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: walk every vector in order and apply the result rules directly.
  task automatic build_expect(output exp_t e);
    int unsigned cnt;
    cnt     = 0;
    e.fvec  = 0;
    e.fdiff = 0;
    e.vec   = NVEC - 1;
    e.lat   = NVEC * (SETTLE + 1);
    for (int v = 0; v < int'(NVEC); v++) begin
      if (err_mask[v] != '0) begin
        if (cnt == 0) begin
          e.fvec  = 32'(v);
          e.fdiff = 32'(err_mask[v]);
        end
        if (cnt < MAXCNT) cnt++;
`ifdef CEC_STOP_ON_FAIL_EN
        e.vec = 32'(v);
        e.lat = 32'((v + 1) * (SETTLE + 1));
        break;
`endif
      end
    end
    e.cnt  = cnt;
    e.pass = (cnt == 0) ? 32'd1 : 32'd0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done pulsed with no sweep expected (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_pass",       32'(pass),       e.pass);
        chk("done_mism_cnt",   32'(mism_cnt),   e.cnt);
        chk("done_first_vec",  32'(first_vec),  e.fvec);
        chk("done_first_diff", 32'(first_diff), e.fdiff);
        chk("done_vec_o",      32'(vec_o),      e.vec);
        chk("done_busy_low",   32'(busy),       32'd0);
        chk("done_latency",    cyc - start_cyc, e.lat);
      end
    end
  end

  task automatic launch(input bit expect_done);
    exp_t e;
    build_expect(e);
    if (expect_done) begin
      sb_q.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("start_busy",     32'(busy),      32'd1);
    chk("start_vec0",     32'(vec_o),     32'd0);
    chk("start_cnt_clr",  32'(mism_cnt),  32'd0);
    chk("start_fvec_clr", 32'(first_vec), 32'd0);
    chk("start_pass_clr", 32'(pass),      32'd0);
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL sweep_timeout: no done after %0d cycles", n);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec_o"},      32'(vec_o),      32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_pass"},       32'(pass),       32'd0);
    chk({tag, "_mism_cnt"},   32'(mism_cnt),   32'd0);
    chk({tag, "_first_vec"},  32'(first_vec),  32'd0);
    chk({tag, "_first_diff"}, 32'(first_diff), 32'd0);
  endtask

  task automatic fill_mask(input int unsigned pct_bad);
    for (int v = 0; v < int'(NVEC); v++)
      err_mask[v] = ($urandom_range(0, 99) < pct_bad) ? OUT_W'($urandom_range(1, 15)) : '0;
  endtask

  initial begin
    int unsigned n;
    fill_mask(0);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Identical netlists.
    launch(1'b1);
    wait_idle();

    // Single-bit difference at one vector.
    fill_mask(0);
    err_mask[12'h0A5] = 4'b0001;
    launch(1'b1);
    wait_idle();

    // Fully inverted: counter saturates.
    for (int v = 0; v < int'(NVEC); v++) err_mask[v] = '1;
    launch(1'b1);
    wait_idle();

    // Random sparse difference maps, below and above saturation.
    fill_mask(3);
    launch(1'b1);
    wait_idle();
    fill_mask(10);
    launch(1'b1);
    // A start while busy must not restart the sweep.
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_done", 32'(done), 32'd1);
    // A start coinciding with done is ignored; results hold.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy", 32'(busy),      32'd0);
    chk("hold_cnt",           32'(mism_cnt),  last_exp.cnt);
    chk("hold_fvec",          32'(first_vec), last_exp.fvec);
    chk("hold_pass",          32'(pass),      last_exp.pass);
    wait_idle();

    // Abort partway: partial results kept, no done pulse.
    fill_mask(0);
    err_mask[10]   = 4'h3;
    err_mask[3000] = 4'h5;
    launch(1'b0);
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_cnt",   32'(mism_cnt),   32'd1);
    chk("abort_fvec",  32'(first_vec),  32'd10);
    chk("abort_fdiff", 32'(first_diff), 32'd3);
    chk("abort_pass",  32'(pass),       32'd0);
    repeat (30) @(negedge clk);
    // start together with abort in idle: nothing starts, results untouched.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy),     32'd0);
    chk("start_abort_cnt",  32'(mism_cnt), 32'd1);
    launch(1'b1);
    wait_idle();

    // Asynchronous reset mid-sweep, then a clean full sweep.
    launch(1'b0);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_mask(0);
    launch(1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
